// File: rtl/nfc_atom_timed_idle.sv
// Drives the NAND PHY bus to the idle pattern and holds it for a programmed
// number of system clocks. The target way's CE can optionally stay asserted
// for the whole wait.
// Latency: an accepted start gives N WAIT cycles, then one DONE cycle
//          (oLastStep). The unit is ready again on the cycle after DONE.
// Backpressure: iStart is taken only while oReady=1. iStart is ignored in
//               WAIT and DONE. iAbort cuts a wait short without oLastStep.
//
// Ports
//   iSystemClock, iReset       : clock, async active-low reset
//   iStart, oReady, oLastStep  : atom handshake shared with sibling atoms
//   iTargetWay, iNumOfCycles,
//   iCEHold                    : request fields, latched on an accepted start
//   iAbort                     : early termination of a running wait
//   oDQ*, oReadEnable, ...     : PHY bus, held at the idle pattern
//   oChipEnable                : 2 bits per way (two PHY phases), active-high

module nfc_atom_timed_idle #(
  parameter int NumberOfWays   = 4,
  parameter int DataWidth      = 32,
  parameter int WaitCountWidth = 16
) (
  input  logic                        iSystemClock,
  input  logic                        iReset,

  input  logic                        iStart,
  input  logic [NumberOfWays-1:0]     iTargetWay,
  input  logic [WaitCountWidth-1:0]   iNumOfCycles,
  input  logic                        iCEHold,
  input  logic                        iAbort,

  output logic                        oReady,
  output logic                        oLastStep,

  output logic                        oDQSOutEnable,
  output logic                        oDQOutEnable,
  output logic [DataWidth/4-1:0]      oDQStrobe,
  output logic [DataWidth-1:0]        oDQ,
  output logic [2*NumberOfWays-1:0]   oChipEnable,
  output logic [3:0]                  oReadEnable,
  output logic [3:0]                  oWriteEnable,
  output logic [3:0]                  oAddressLatchEnable,
  output logic [3:0]                  oCommandLatchEnable
);

  // The DQ bus is four PHY phases of one byte each, so DataWidth must
  // split evenly into four phases.
  if ((DataWidth % 4) != 0) begin : g_bad_width
    $error("nfc_atom_timed_idle: DataWidth must be a multiple of 4");
  end

  localparam logic [WaitCountWidth-1:0] CountZero = '0;
  localparam logic [WaitCountWidth-1:0] CountOne  = {{(WaitCountWidth-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                      state_q, state_d;
  logic [WaitCountWidth-1:0]   count_q, count_d;
  logic [NumberOfWays-1:0]     way_q,   way_d;
  logic                        ce_hold_q, ce_hold_d;

  // ---------------------------------------------------------------------
  // State and latched request fields
  // ---------------------------------------------------------------------
  always_ff @(posedge iSystemClock or negedge iReset) begin
    if (!iReset) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      way_q     <= '0;
      ce_hold_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      way_q     <= way_d;
      ce_hold_q <= ce_hold_d;
    end
  end

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    way_d     = way_q;
    ce_hold_d = ce_hold_q;

    unique case (state_q)
      S_IDLE: begin
        if (iStart) begin
          way_d     = iTargetWay;
          count_d   = iNumOfCycles;
          ce_hold_d = iCEHold;
          // A zero-length wait skips straight to the completion cycle.
          state_d   = (iNumOfCycles == CountZero) ? S_DONE : S_WAIT;
        end
      end

      S_WAIT: begin
        if (iAbort) begin
          // Abort wins over the count reaching its end. No completion pulse.
          state_d = S_IDLE;
          count_d = '0;
        end else begin
          // The counter holds N on the first WAIT cycle. Leaving when it
          // reads 1 gives exactly N WAIT cycles. WAIT is never entered with
          // a zero count, so the decrement cannot wrap.
          count_d = count_q - CountOne;
          if (count_q == CountOne) begin
            state_d = S_DONE;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        count_d = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Outputs: decoded from registered state and latched fields only, so no
  // input reaches an output in the same cycle.
  // ---------------------------------------------------------------------
  logic busy_w;
  assign busy_w = (state_q == S_WAIT) || (state_q == S_DONE);

  // CE is driven through DONE as well, so it is released on the same edge
  // that returns the unit to IDLE. Every selected way is driven, so a
  // non-one-hot way select enables several ways at once.
  always_comb begin
    oChipEnable = '0;
    if (busy_w && ce_hold_q) begin
      for (int w = 0; w < NumberOfWays; w++) begin
        if (way_q[w]) begin
          oChipEnable[2*w +: 2] = 2'b11;
        end
      end
    end
  end

  assign oReady    = (state_q == S_IDLE);
  assign oLastStep = (state_q == S_DONE);

  // Idle bus pattern. RE stays high for the first two phases, and every
  // other strobe and data line is parked low.
  assign oDQSOutEnable       = 1'b1;
  assign oDQOutEnable        = 1'b1;
  assign oDQStrobe           = '0;
  assign oDQ                 = '0;
  assign oReadEnable         = 4'b0011;
  assign oWriteEnable        = 4'b0000;
  assign oAddressLatchEnable = 4'b0000;
  assign oCommandLatchEnable = 4'b0000;

endmodule

// File: tb/tb_nfc_atom_timed_idle.sv
module tb_nfc_atom_timed_idle;

  localparam int NW = 4;
  localparam int DW = 32;
  localparam int CW = 16;
  localparam int BUSY_LIMIT = 70000;

  logic              iSystemClock;
  logic              iReset;
  logic              iStart;
  logic [NW-1:0]     iTargetWay;
  logic [CW-1:0]     iNumOfCycles;
  logic              iCEHold;
  logic              iAbort;
  logic              oReady;
  logic              oLastStep;
  logic              oDQSOutEnable;
  logic              oDQOutEnable;
  logic [DW/4-1:0]   oDQStrobe;
  logic [DW-1:0]     oDQ;
  logic [2*NW-1:0]   oChipEnable;
  logic [3:0]        oReadEnable;
  logic [3:0]        oWriteEnable;
  logic [3:0]        oAddressLatchEnable;
  logic [3:0]        oCommandLatchEnable;

  nfc_atom_timed_idle #(
    .NumberOfWays  (NW),
    .DataWidth     (DW),
    .WaitCountWidth(CW)
  ) dut (
    .iSystemClock       (iSystemClock),
    .iReset             (iReset),
    .iStart             (iStart),
    .iTargetWay         (iTargetWay),
    .iNumOfCycles       (iNumOfCycles),
    .iCEHold            (iCEHold),
    .iAbort             (iAbort),
    .oReady             (oReady),
    .oLastStep          (oLastStep),
    .oDQSOutEnable      (oDQSOutEnable),
    .oDQOutEnable       (oDQOutEnable),
    .oDQStrobe          (oDQStrobe),
    .oDQ                (oDQ),
    .oChipEnable        (oChipEnable),
    .oReadEnable        (oReadEnable),
    .oWriteEnable       (oWriteEnable),
    .oAddressLatchEnable(oAddressLatchEnable),
    .oCommandLatchEnable(oCommandLatchEnable)
  );

  initial begin
    iSystemClock = 1'b0;
    forever #5 iSystemClock = ~iSystemClock;
  end

  int unsigned cyc = 0;
  always @(posedge iSystemClock) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Scoreboard: one entry per atom that is expected to complete.
  typedef struct {
    int unsigned    done_cyc;
    logic [2*NW-1:0] ce;
  } exp_t;
  exp_t sb[$];

  // Reference CE pattern for a latched request.
  function automatic logic [2*NW-1:0] ref_ce(input logic [NW-1:0] way, input logic hold);
    logic [2*NW-1:0] r;
    r = '0;
    if (hold)
      for (int w = 0; w < NW; w++)
        if (way[w]) r[2*w +: 2] = 2'b11;
    return r;
  endfunction

  // Completion monitor, sampled on the falling edge.
  always @(negedge iSystemClock) begin
    if (oLastStep === 1'b1) begin
      if (sb.size() == 0) begin
        check_eq("unexpected_laststep", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_eq("laststep_cycle", 64'(cyc), 64'(e.done_cyc));
        check_eq("laststep_ce", 64'(oChipEnable), 64'(e.ce));
      end
    end
  end

  task automatic tick;
    @(posedge iSystemClock);
    #1;
  endtask

  // Drive a start for one cycle. On return the start has been accepted and
  // the bench is one cycle past the accepting edge.
  task automatic start_atom(input logic [NW-1:0] way, input int n, input logic hold, input bit expect_done);
    exp_t e;
    iStart       = 1'b1;
    iTargetWay   = way;
    iNumOfCycles = CW'(n);
    iCEHold      = hold;
    if (expect_done) begin
      e.done_cyc = cyc + 1 + n;
      e.ce       = ref_ce(way, hold);
      sb.push_back(e);
    end
    tick;
    iStart = 1'b0;
  endtask

  // Count busy cycles until oReady returns. Optionally pulse a stray start
  // or an abort at a given busy-cycle index.
  task automatic run_busy(input int inject_at, input int abort_at,
                          output int busy, output logic [2*NW-1:0] ce_or);
    busy  = 0;
    ce_or = '0;
    while (oReady !== 1'b1 && busy < BUSY_LIMIT) begin
      ce_or = ce_or | oChipEnable;
      if (busy == inject_at) begin
        iStart       = 1'b1;
        iNumOfCycles = 16'd9;
        iTargetWay   = 4'b1111;
        iCEHold      = 1'b1;
      end else begin
        iStart = 1'b0;
      end
      iAbort = (busy == abort_at);
      busy++;
      tick;
    end
    iStart = 1'b0;
    iAbort = 1'b0;
    if (busy >= BUSY_LIMIT) check_eq("busy_timeout", 64'(busy), 0);
  endtask

  int              busy;
  logic [2*NW-1:0] ce_or;

  initial begin
    iReset       = 1'b0;
    iStart       = 1'b0;
    iTargetWay   = '0;
    iNumOfCycles = '0;
    iCEHold      = 1'b0;
    iAbort       = 1'b0;

    // Constant outputs are already valid while reset is held.
    #2;
    check_eq("rst_read_enable", 64'(oReadEnable), 64'h3);
    check_eq("rst_ready", 64'(oReady), 1);
    tick; tick;
    iReset = 1'b1;
    tick;

    check_eq("idle_ready", 64'(oReady), 1);
    check_eq("idle_ce", 64'(oChipEnable), 0);
    check_eq("idle_re", 64'(oReadEnable), 64'h3);
    check_eq("idle_dq", 64'(oDQ), 0);
    check_eq("idle_dqs_oe", 64'(oDQSOutEnable), 1);
    check_eq("idle_dq_oe", 64'(oDQOutEnable), 1);
    check_eq("idle_we", 64'(oWriteEnable), 0);
    check_eq("idle_laststep", 64'(oLastStep), 0);

    // N=5 with CE hold on way 2.
    start_atom(4'b0100, 5, 1'b1, 1'b1);
    check_eq("n5_ce_first", 64'(oChipEnable), 64'h30);
    run_busy(-1, -1, busy, ce_or);
    check_eq("n5_busy", 64'(busy), 6);
    check_eq("n5_ce_or", 64'(ce_or), 64'h30);
    check_eq("n5_ce_after", 64'(oChipEnable), 0);

    // N=0: straight to DONE.
    start_atom(4'b0010, 0, 1'b0, 1'b1);
    run_busy(-1, -1, busy, ce_or);
    check_eq("n0_busy", 64'(busy), 1);
    check_eq("n0_ce_or", 64'(ce_or), 0);

    // Back-to-back: start in the first IDLE cycle after DONE, N=1, ways 0 and 2.
    start_atom(4'b0101, 1, 1'b1, 1'b1);
    run_busy(-1, -1, busy, ce_or);
    check_eq("multi_busy", 64'(busy), 2);
    check_eq("multi_ce_or", 64'(ce_or), 64'h33);

    // All-zero way select: no CE even with hold.
    start_atom(4'b0000, 2, 1'b1, 1'b1);
    run_busy(-1, -1, busy, ce_or);
    check_eq("noway_busy", 64'(busy), 3);
    check_eq("noway_ce_or", 64'(ce_or), 0);

    // N=3 without CE hold, with a stray start during WAIT.
    tick;
    start_atom(4'b0010, 3, 1'b0, 1'b1);
    run_busy(1, -1, busy, ce_or);
    check_eq("ign_busy", 64'(busy), 4);
    check_eq("ign_ce_or", 64'(ce_or), 0);
    tick;
    check_eq("ign_ready_after", 64'(oReady), 1);

    // N=10, abort in the 4th WAIT cycle: no completion pulse.
    start_atom(4'b0001, 10, 1'b1, 1'b0);
    run_busy(-1, 3, busy, ce_or);
    check_eq("abort_busy", 64'(busy), 4);
    check_eq("abort_ce_or", 64'(ce_or), 64'h03);
    check_eq("abort_ce_after", 64'(oChipEnable), 0);
    check_eq("abort_ready", 64'(oReady), 1);

    // An abort while IDLE has no effect.
    iAbort = 1'b1;
    tick;
    iAbort = 1'b0;
    check_eq("idle_abort_ready", 64'(oReady), 1);

    // Abort is ignored in DONE: N=1, abort on the DONE cycle.
    start_atom(4'b1000, 1, 1'b1, 1'b1);
    run_busy(-1, 1, busy, ce_or);
    check_eq("done_abort_busy", 64'(busy), 2);

    // Maximum count: exactly 65536 busy cycles, no wrap.
    start_atom(4'b0100, 65535, 1'b1, 1'b1);
    run_busy(-1, -1, busy, ce_or);
    check_eq("max_busy", 64'(busy), 65536);
    check_eq("max_ce_or", 64'(ce_or), 64'h30);

    // Async reset in the 2nd WAIT cycle.
    tick;
    start_atom(4'b1000, 8, 1'b1, 1'b0);
    check_eq("rst_pre_ce", 64'(oChipEnable), 64'hC0);
    tick;
    #2;
    iReset = 1'b0;
    #1;
    check_eq("arst_ready", 64'(oReady), 1);
    check_eq("arst_ce", 64'(oChipEnable), 0);
    check_eq("arst_laststep", 64'(oLastStep), 0);
    check_eq("arst_re", 64'(oReadEnable), 64'h3);
    tick; tick;
    iReset = 1'b1;
    tick;
    check_eq("arst_idle_ready", 64'(oReady), 1);

    // Fresh start after the reset behaves normally.
    start_atom(4'b0001, 2, 1'b1, 1'b1);
    run_busy(-1, -1, busy, ce_or);
    check_eq("post_rst_busy", 64'(busy), 3);
    check_eq("post_rst_ce_or", 64'(ce_or), 64'h03);

    tick; tick;
    check_eq("sb_empty", 64'(sb.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/nfc_atom_timed_idle.md
# nfc_atom_timed_idle

Parametrised, timed successor to the NAND idle atom. It drives the NAND PHY bus to the idle pattern and can hold it for a programmed number of system clocks, for example tWHR, tADL or tCCS gaps between command atoms. It can optionally keep the target way's chip enable asserted through the wait. It sits beside the other command atoms under the way-command arbiter and uses the same start/ready/last-step handshake.

## Interface
- NumberOfWays, 4, number of NAND ways; chip enable is 2 bits per way (two PHY phases).
- DataWidth, 32, PHY DQ bus width (4 phases × 8 bits); must be a multiple of 4.
- WaitCountWidth, 16, width of the wait-cycle count.
- iSystemClock  in  1  system clock; all state changes on its rising edge.
- iReset  in  1  asynchronous, active-low reset.
- iStart  in  1  one-cycle request; accepted only when oReady=1.
- iTargetWay  in  NumberOfWays  way select, latched on accepted iStart; normally one-hot.
- iNumOfCycles  in  WaitCountWidth  wait length N, latched on accepted iStart.
- iCEHold  in  1  latched on accepted iStart; 1 = assert the target way's CE during WAIT.
- iAbort  in  1  terminates a wait early; no effect in IDLE.
- oReady  out  1  1 only in IDLE.
- oLastStep  out  1  one-cycle completion pulse.
- oDQSOutEnable  out  1  constant 1.
- oDQOutEnable  out  1  constant 1.
- oDQStrobe  out  DataWidth/4  constant 0.
- oDQ  out  DataWidth  constant 0.
- oChipEnable  out  2*NumberOfWays  per-way CE, 2 bits per way, active-high toward PHY.
- oReadEnable  out  4  constant 4'b0011.
- oWriteEnable  out  4  constant 4'b0000.
- oAddressLatchEnable  out  4  constant 0.
- oCommandLatchEnable  out  4  constant 0.

## Operation
- FSM states: IDLE, WAIT, DONE. Reset state is IDLE.
- IDLE:
  - oReady=1, oLastStep=0, oChipEnable all 0.
  - On iStart, latch iTargetWay, iNumOfCycles and iCEHold, then load counter with N.
  - If N=0, go to DONE; otherwise go to WAIT.
- WAIT:
  - oReady=0.
  - oChipEnable bits {2w+1,2w}=2'b11 for each latched way bit w, only when latched iCEHold=1; all other bits 0.
  - Counter decrements by 1 each cycle. When counter=1, go to DONE, so exactly N cycles are spent in WAIT.
  - iAbort=1 goes to IDLE next cycle, with no oLastStep and the counter cleared.
  - iAbort has priority over the count-end transition.
- DONE:
  - oLastStep=1 and oReady=0 for exactly one cycle.
  - oChipEnable is as in WAIT, so CE is released together with the return to IDLE.
  - Always goes to IDLE; iAbort is ignored.
- iStart outside IDLE is ignored: no latch, no effect on the counter.
- A non-one-hot iTargetWay is honoured as given; all selected ways get CE, and an all-zero value gives no CE.
- Outputs other than oReady, oLastStep and oChipEnable are constant in every state, including during reset.
- Counter is WaitCountWidth bits, unsigned, with no wrap. The maximum N is 2^WaitCountWidth−1 WAIT cycles.

## Timing
- Reset values:
  - oReady=1, oLastStep=0, oChipEnable=0.
  - Constant outputs as listed under Interface.
  - Counter=0 and latched fields=0.
- Reset asserted mid-WAIT or in DONE forces IDLE immediately (asynchronously); no oLastStep is produced.
- All outputs are registered from FSM state and latched fields; there is no combinational path from inputs to outputs.
- iStart accepted at edge k:
  - N≥1: WAIT during cycles k+1…k+N, DONE at cycle k+N+1, oReady=1 again at k+N+2.
  - N=0: DONE at cycle k+1, oReady=1 at k+2.
- Back-to-back: iStart may be asserted in the first IDLE cycle after DONE, giving a minimum period of N+2 cycles per atom.

## Test plan
- Reset release: check oReady=1, oChipEnable=0, oReadEnable=4'b0011, oDQ=0 and oDQSOutEnable=1. Assert iStart with N=5, way=4'b0100, iCEHold=1 → oReady low for 6 cycles, oChipEnable=8'b0011_0000 for 6 cycles, oLastStep high in the 6th cycle only.
- N=0 → oLastStep one cycle after the start edge, oChipEnable stays 0, oReady back after 2 cycles.
- N=3 with iCEHold=0 → oChipEnable stays 0 throughout, oLastStep at cycle 4. A second iStart pulsed during WAIT with N=9 is ignored, so total busy is 4 cycles.
- N=10, iAbort at the 4th WAIT cycle → IDLE next cycle, oLastStep never asserted, CE dropped.
- N=65535 (WaitCountWidth=16) → oLastStep exactly 65536 cycles after start, with no wrap.
- iReset low in the 2nd WAIT cycle → outputs immediately at reset values, no oLastStep. After release, a fresh start with N=2 behaves normally.
